// File: rtl/vga_sprite_dbuf_if.sv
// -----------------------------------------------------------------------------
// vga_sprite_dbuf_if
// Avalon-MM bus bundle for the CPU side of the sprite double buffer.
//
// Signals:
//   address        ADDR_W+1  MSB=0 memory word, MSB=1 register offset
//   chipselect     1         slave select
//   read / write   1         access strobes
//   byteenable     DATA_W/8  byte lanes for memory writes
//   writedata      DATA_W    write data
//   readdata       DATA_W    read data, valid with readdatavalid
//   readdatavalid  1         one-cycle pulse, one cycle after an accepted read
//
// Modports: master (CPU / bench side), slave (sprite store side).
// -----------------------------------------------------------------------------
interface vga_sprite_dbuf_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W:0]       address;
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [DATA_W/8-1:0]   byteenable;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/vga_sprite_dbuf.sv
// -----------------------------------------------------------------------------
// vga_sprite_dbuf
// Double-buffered sprite store. The CPU writes and reads back the back bank
// over Avalon-MM; the video pipeline fetches pixels from the front bank.
// Banks swap only on frame_start while a swap is pending, so a frame is
// always scanned out of a single bank.
//
// Ports:
//   clk, reset_n        single clock, asynchronous active-low reset
//   avs (slave)         Avalon-MM CPU port (see vga_sprite_dbuf_if)
//   frame_start         one-cycle pulse at start of each frame
//   pix_rd, pix_addr    pixel fetch request and pixel index (front bank)
//   pix_data, pix_valid fetched pixel, one cycle after pix_rd
//   pix_opaque          colour-key result aligned with pix_data
//   swap_done           one-cycle pulse in the first cycle after a swap
//
// Registers (address MSB=1, offset = low 2 bits):
//   0 CTRL   W: bit0 request swap, bit1 cancel (cancel wins); R: bit1=pending
//   1 STATUS R: bit0 front_sel, bit1 pending, bits[15:8] frame_cnt
//   2 KEY    colour key (only with SPRITE_COLORKEY_EN), else reads 0
//   3        reads 0, writes ignored
//
// Build option: define SPRITE_COLORKEY_EN to enable the KEY register and the
// pix_opaque compare; otherwise pix_opaque is tied to 1.
// -----------------------------------------------------------------------------
module vga_sprite_dbuf #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int PIX_W  = 16
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    vga_sprite_dbuf_if.slave                           avs,
    input  logic                                       frame_start,
    input  logic                                       pix_rd,
    input  logic [ADDR_W+$clog2(DATA_W/PIX_W)-1:0]     pix_addr,
    output logic [PIX_W-1:0]                           pix_data,
    output logic                                       pix_valid,
    output logic                                       pix_opaque,
    output logic                                       swap_done
);
    localparam int LANES      = DATA_W / PIX_W;
    localparam int LANE_W     = $clog2(LANES);
    localparam int LANE_SEL_W = (LANE_W > 0) ? LANE_W : 1;
    localparam int PIX_ADDR_W = ADDR_W + LANE_W;
    localparam int BYTES      = DATA_W / 8;
    localparam int DEPTH      = 2 ** ADDR_W;

    // Both banks in one array: index = {bank, word}.
    logic [DATA_W-1:0] mem [0:2*DEPTH-1];

    logic              front_sel;
    logic              pending;
    logic [7:0]        frame_cnt;

    // CPU access decode
    logic              sel_reg;
    logic [1:0]        reg_off;
    logic              mem_wr, mem_rd, reg_wr, reg_rd;
    logic              ctrl_set, ctrl_clr, do_swap;
    logic [ADDR_W:0]   cpu_idx;
    logic [ADDR_W:0]   pix_idx;
    logic [DATA_W-1:0] reg_rdata;

    // Read-return stage
    logic              rd_vld_p1;
    logic              rd_mem_p1;
    logic [DATA_W-1:0] cpu_q_p1;
    logic [DATA_W-1:0] reg_q_p1;

    // Pixel-return stage
    logic [DATA_W-1:0]     pix_word_p1;
    logic [LANE_SEL_W-1:0] lane_p1;
    logic                  pix_seen;
    logic [PIX_W-1:0]      pix_lane;

`ifdef SPRITE_COLORKEY_EN
    logic [PIX_W-1:0]      key;
    logic [PIX_W-1:0]      key_p1;
`endif

    assign sel_reg = avs.address[ADDR_W];
    assign reg_off = avs.address[1:0];
    // A write in the same cycle as a read takes priority and suppresses the read.
    assign mem_wr  = avs.chipselect && avs.write && !sel_reg;
    assign reg_wr  = avs.chipselect && avs.write &&  sel_reg;
    assign mem_rd  = avs.chipselect && avs.read && !avs.write && !sel_reg;
    assign reg_rd  = avs.chipselect && avs.read && !avs.write &&  sel_reg;

    assign ctrl_set = reg_wr && (reg_off == 2'd0) && avs.writedata[0];
    assign ctrl_clr = reg_wr && (reg_off == 2'd0) && avs.writedata[1];
    // A cancel landing with frame_start clears the request before it can swap.
    assign do_swap  = frame_start && pending && !ctrl_clr;

    // CPU always targets the back bank, pixels the front bank (pre-swap value).
    assign cpu_idx = {~front_sel, avs.address[ADDR_W-1:0]};
    assign pix_idx = {front_sel, pix_addr[PIX_ADDR_W-1:LANE_W]};

    always_comb begin
        reg_rdata = '0;
        case (reg_off)
            2'd0:    reg_rdata = DATA_W'({pending, 1'b0});
            2'd1:    reg_rdata = DATA_W'({frame_cnt, 6'b0, pending, front_sel});
`ifdef SPRITE_COLORKEY_EN
            2'd2:    reg_rdata = DATA_W'(key);
`endif
            default: reg_rdata = '0;
        endcase
    end

    // ---- stage p0 -> p1: memory ports ----
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < BYTES; b++) begin
                if (avs.byteenable[b]) begin
                    mem[cpu_idx][8*b +: 8] <= avs.writedata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_rd) cpu_q_p1 <= mem[cpu_idx];
    end

    always_ff @(posedge clk) begin
        if (reg_rd) reg_q_p1 <= reg_rdata;
    end

    // Pixel word, lane and key are captured together so the result holds
    // steady between requests.
    always_ff @(posedge clk) begin
        if (pix_rd) begin
            pix_word_p1 <= mem[pix_idx];
            lane_p1     <= (LANE_W > 0) ? pix_addr[LANE_SEL_W-1:0] : '0;
`ifdef SPRITE_COLORKEY_EN
            key_p1      <= key;
`endif
        end
    end

    // ---- control state ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_sel <= 1'b0;
            pending   <= 1'b0;
            frame_cnt <= 8'd0;
            swap_done <= 1'b0;
            rd_vld_p1 <= 1'b0;
            rd_mem_p1 <= 1'b0;
            pix_valid <= 1'b0;
            pix_seen  <= 1'b0;
`ifdef SPRITE_COLORKEY_EN
            key       <= '0;
`endif
        end else begin
            rd_vld_p1 <= mem_rd || reg_rd;
            rd_mem_p1 <= mem_rd;
            pix_valid <= pix_rd;
            if (pix_rd) pix_seen <= 1'b1;

            if (frame_start) frame_cnt <= frame_cnt + 8'd1;
            if (do_swap) front_sel <= ~front_sel;
            swap_done <= do_swap;

            // A set arriving with frame_start re-arms for the next frame.
            if (ctrl_clr)      pending <= 1'b0;
            else if (ctrl_set) pending <= 1'b1;
            else if (do_swap)  pending <= 1'b0;

`ifdef SPRITE_COLORKEY_EN
            if (reg_wr && (reg_off == 2'd2)) key <= avs.writedata[PIX_W-1:0];
`endif
        end
    end

    // ---- stage p1: output select ----
    always_comb begin
        pix_lane = pix_word_p1[PIX_W*int'(lane_p1) +: PIX_W];
    end

    assign avs.readdata      = rd_vld_p1 ? (rd_mem_p1 ? cpu_q_p1 : reg_q_p1) : '0;
    assign avs.readdatavalid = rd_vld_p1;
    assign pix_data          = pix_seen ? pix_lane : '0;

`ifdef SPRITE_COLORKEY_EN
    assign pix_opaque = pix_seen ? (pix_lane != key_p1) : 1'b1;
`else
    assign pix_opaque = 1'b1;
`endif

endmodule

// File: tb/tb_vga_sprite_dbuf.sv
// -----------------------------------------------------------------------------
// tb_vga_sprite_dbuf
// Directed bench for vga_sprite_dbuf (ADDR_W=10, DATA_W=32, PIX_W=16).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_vga_sprite_dbuf;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int PIX_W  = 16;
    localparam int PIX_ADDR_W = ADDR_W + 1;

    localparam logic [ADDR_W:0] CTRL   = 11'h400;
    localparam logic [ADDR_W:0] STATUS = 11'h401;
    localparam logic [ADDR_W:0] KEYREG = 11'h402;
    localparam logic [ADDR_W:0] REG3   = 11'h403;

`ifdef SPRITE_COLORKEY_EN
    localparam logic [31:0] KEY_RB   = 32'h0000_5555;
    localparam logic        OPQ_5555 = 1'b0;
`else
    localparam logic [31:0] KEY_RB   = 32'h0;
    localparam logic        OPQ_5555 = 1'b1;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic frame_start = 1'b0;
    logic pix_rd = 1'b0;
    logic [PIX_ADDR_W-1:0] pix_addr = '0;
    logic [PIX_W-1:0] pix_data;
    logic pix_valid, pix_opaque, swap_done;

    int checks = 0;
    int errors = 0;

    vga_sprite_dbuf_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vga_sprite_dbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIX_W(PIX_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .avs         (bus),
        .frame_start (frame_start),
        .pix_rd      (pix_rd),
        .pix_addr    (pix_addr),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_opaque  (pix_opaque),
        .swap_done   (swap_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.byteenable = '0;
        bus.writedata  = '0;
    endtask

    task automatic cpu_write(input logic [ADDR_W:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        bus.byteenable = be;
        tick();
        bus_idle();
    endtask

    // Read, then check data/valid one cycle later and valid low the cycle after.
    task automatic cpu_read(input string tag, input logic [ADDR_W:0] a, input logic [31:0] exp);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        tick();
        bus_idle();
        chk({tag, "_vld"}, 64'(bus.readdatavalid), 64'd1);
        chk(tag, 64'(bus.readdata), 64'(exp));
        tick();
        chk({tag, "_vld_end"}, 64'(bus.readdatavalid), 64'd0);
    endtask

    task automatic fetch(input string tag, input logic [PIX_ADDR_W-1:0] a,
                         input logic [15:0] exp, input logic opq);
        pix_rd   = 1'b1;
        pix_addr = a;
        tick();
        pix_rd   = 1'b0;
        chk({tag, "_vld"}, 64'(pix_valid), 64'd1);
        chk(tag, 64'(pix_data), 64'(exp));
        chk({tag, "_opq"}, 64'(pix_opaque), 64'(opq));
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        bus_idle();
        // Reset and idle
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk("rst_readdata", 64'(bus.readdata), 64'd0);
        chk("rst_rdvalid", 64'(bus.readdatavalid), 64'd0);
        chk("rst_pix_data", 64'(pix_data), 64'd0);
        chk("rst_pix_valid", 64'(pix_valid), 64'd0);
        chk("rst_swap_done", 64'(swap_done), 64'd0);
        chk("rst_pix_opaque", 64'(pix_opaque), 64'd1);
        cpu_read("rst_status", STATUS, 32'h0);

        // Byte-enable merge
        cpu_write(11'd5, 32'h1122_3344, 4'hF);
        cpu_write(11'd5, 32'hDEAD_BEEF, 4'b0101);
        cpu_read("be_merge", 11'd5, 32'h11AD_33EF);

        // Load sprite, request swap, swap on frame_start
        cpu_write(11'd5, 32'hAAAA_5555, 4'hF);
        cpu_write(KEYREG, 32'h0000_5555, 4'hF);
        cpu_read("key_rb", KEYREG, KEY_RB);
        cpu_write(CTRL, 32'h1, 4'hF);
        cpu_read("ctrl_pending", CTRL, 32'h2);
        frame();
        chk("swap1_done", 64'(swap_done), 64'd1);
        tick();
        chk("swap1_done_end", 64'(swap_done), 64'd0);
        cpu_read("status_swap1", STATUS, 32'h0000_0101);

        // Pixel fetch from new front bank, back-to-back then hold
        pix_rd = 1'b1;
        pix_addr = 11'd10;
        tick();
        chk("b2b_lane0_vld", 64'(pix_valid), 64'd1);
        chk("b2b_lane0", 64'(pix_data), 64'h5555);
        chk("b2b_lane0_opq", 64'(pix_opaque), 64'(OPQ_5555));
        pix_addr = 11'd11;
        tick();
        pix_rd = 1'b0;
        chk("b2b_lane1_vld", 64'(pix_valid), 64'd1);
        chk("b2b_lane1", 64'(pix_data), 64'hAAAA);
        chk("b2b_lane1_opq", 64'(pix_opaque), 64'd1);
        tick();
        chk("hold_vld", 64'(pix_valid), 64'd0);
        chk("hold_data", 64'(pix_data), 64'hAAAA);

        // CPU writes now hit the other bank; front bank unaffected
        cpu_write(11'd5, 32'h1234_5678, 4'hF);
        cpu_read("back_bank", 11'd5, 32'h1234_5678);
        fetch("front_intact", 11'd10, 16'h5555, OPQ_5555);

        // Set in the same cycle as frame_start: no swap now, swap next frame
        bus.chipselect = 1'b1;
        bus.write = 1'b1;
        bus.address = CTRL;
        bus.writedata = 32'h1;
        bus.byteenable = 4'hF;
        frame_start = 1'b1;
        tick();
        bus_idle();
        frame_start = 1'b0;
        chk("set_with_frame_noswap", 64'(swap_done), 64'd0);
        cpu_read("status_armed", STATUS, 32'h0000_0203);
        frame();
        chk("swap2_done", 64'(swap_done), 64'd1);
        cpu_read("status_swap2", STATUS, 32'h0000_0300);

        // Set then cancel (CTRL=3) -> no swap
        cpu_write(CTRL, 32'h1, 4'hF);
        cpu_write(CTRL, 32'h3, 4'hF);
        cpu_read("ctrl_cancelled", CTRL, 32'h0);
        frame();
        chk("cancel_noswap", 64'(swap_done), 64'd0);
        cpu_read("status_cancel", STATUS, 32'h0000_0400);

        // Cancel in the same cycle as frame_start with pending set
        cpu_write(CTRL, 32'h1, 4'hF);
        bus.chipselect = 1'b1;
        bus.write = 1'b1;
        bus.address = CTRL;
        bus.writedata = 32'h2;
        bus.byteenable = 4'hF;
        frame_start = 1'b1;
        tick();
        bus_idle();
        frame_start = 1'b0;
        chk("cancel_with_frame_noswap", 64'(swap_done), 64'd0);
        cpu_read("status_cancel2", STATUS, 32'h0000_0500);

        // Read and write together: write wins, no readdatavalid
        bus.chipselect = 1'b1;
        bus.read = 1'b1;
        bus.write = 1'b1;
        bus.address = 11'd7;
        bus.writedata = 32'hCAFE_F00D;
        bus.byteenable = 4'hF;
        tick();
        bus_idle();
        chk("rw_no_valid", 64'(bus.readdatavalid), 64'd0);
        cpu_read("rw_write_won", 11'd7, 32'hCAFE_F00D);

        // Unused offset
        cpu_write(REG3, 32'hFFFF_FFFF, 4'hF);
        cpu_read("reg3_zero", REG3, 32'h0);

        // frame_cnt wrap: 5 + 251 = 256 -> 0
        for (int i = 0; i < 251; i++) frame();
        cpu_read("cnt_wrap", STATUS, 32'h0);

        // Reset during an outstanding read
        cpu_write(CTRL, 32'h1, 4'hF);
        frame();
        cpu_read("pre_reset_status", STATUS, 32'h0000_0101);
        bus.chipselect = 1'b1;
        bus.read = 1'b1;
        bus.address = STATUS;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.readdatavalid), 64'd0);
        tick();
        bus_idle();
        chk("rst_abandon_valid", 64'(bus.readdatavalid), 64'd0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_valid", 64'(bus.readdatavalid), 64'd0);
        chk("post_rst_opaque", 64'(pix_opaque), 64'd1);
        cpu_read("post_rst_status", STATUS, 32'h0);
        cpu_read("post_rst_key", KEYREG, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
